// File: rtl/pipe_ctrl_regs.sv
// rtl/pipe_ctrl_regs.sv - pipeline register chain with per-stage valid and stall/flush control
//
// Purpose:
//   NSTAGE-deep chain of WIDTH-bit pipeline registers. Stage 0 is the youngest
//   (F/D boundary), stage NSTAGE-1 the oldest (M/W boundary). A stall request
//   on bit j holds stages 0..j, and a flush on bit k empties stages 0..k. The
//   first stage above a held or flushed range receives a bubble. A flush wins
//   over a stall for the stages it covers.
//
// Configuration:
//   PIPE_DATA_ZERO_EN - when defined, any stage that loads a bubble or is
//   killed also has its payload cleared to zero. Otherwise stale payload is
//   left in place, and consumers must qualify it with stage_valid.
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   in_valid/in_data     new beat for stage 0
//   in_ready             stage 0 consumes in_data this cycle
//   stall_req[NSTAGE]    bit j holds stages 0..j
//   flush[NSTAGE]        bit k discards stages 0..k
//   stage_valid/_data    per-stage valid and payload (stage i at [i*WIDTH +: WIDTH])
//   stage_adv[NSTAGE]    stage i loads new content at the next edge
//   out_valid/out_data   oldest stage contents
//   out_fire             oldest stage retires this cycle

module pipe_ctrl_regs #(
  parameter int NSTAGE = 4,
  parameter int WIDTH  = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic [NSTAGE-1:0]        stall_req,
  input  logic [NSTAGE-1:0]        flush,
  output logic [NSTAGE-1:0]        stage_valid,
  output logic [NSTAGE*WIDTH-1:0]  stage_data,
  output logic [NSTAGE-1:0]        stage_adv,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_fire
);

  logic [NSTAGE-1:0] holdVec;
  logic [NSTAGE-1:0] killVec;
  logic [NSTAGE-1:0] moveVec;
  logic [NSTAGE-1:0] srcValid;
  logic [NSTAGE-1:0] validReg;
  logic [WIDTH-1:0]  dataReg [NSTAGE];
  logic [WIDTH-1:0]  srcData [NSTAGE];

  // hold/kill of stage i is the OR of all request bits at or above i, so a
  // request on an older stage always covers every younger stage too.
  always_comb begin
    holdVec = '0;
    killVec = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      holdVec[i] = |(stall_req >> i);
      killVec[i] = |(flush >> i);
    end
  end

  // moveVec[i]: stage i hands a real instruction to stage i+1 (or retires).
  assign moveVec  = validReg & ~holdVec & ~killVec;
  assign srcValid = {moveVec[NSTAGE-2:0], in_valid};

  always_comb begin
    srcData[0] = in_data;
    for (int i = 1; i < NSTAGE; i++) begin
      srcData[i] = dataReg[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      validReg <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        dataReg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSTAGE; i++) begin
        if (killVec[i]) begin
          validReg[i] <= 1'b0;
`ifdef PIPE_DATA_ZERO_EN
          dataReg[i] <= '0;
`endif
        end else if (!holdVec[i]) begin
          validReg[i] <= srcValid[i];
`ifdef PIPE_DATA_ZERO_EN
          dataReg[i] <= srcValid[i] ? srcData[i] : '0;
`else
          dataReg[i] <= srcData[i];
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < NSTAGE; g++) begin : gPack
    assign stage_data[g*WIDTH +: WIDTH] = dataReg[g];
  end

  assign stage_valid = validReg;
  assign stage_adv   = killVec | ~holdVec;
  assign in_ready    = resetn & ~holdVec[0] & ~killVec[0];
  assign out_valid   = validReg[NSTAGE-1];
  assign out_data    = dataReg[NSTAGE-1];
  assign out_fire    = resetn & moveVec[NSTAGE-1];

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// tb/tb_pipe_ctrl_regs.sv - randomized and directed checks of pipe_ctrl_regs against a slot model
module tb_pipe_ctrl_regs;
  localparam int NS = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            resetn;
  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            in_ready;
  logic [NS-1:0]   stall_req;
  logic [NS-1:0]   flush;
  logic [NS-1:0]   stage_valid;
  logic [NS*W-1:0] stage_data;
  logic [NS-1:0]   stage_adv;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_fire;

  pipe_ctrl_regs #(.NSTAGE(NS), .WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
    .stage_valid(stage_valid), .stage_data(stage_data), .stage_adv(stage_adv),
    .out_valid(out_valid), .out_data(out_data), .out_fire(out_fire)
  );

  always #5 clk = ~clk;

  int nVec  = 0;
  int nFail = 0;

  // Model: one slot per stage, holding a presence flag and a payload.
  bit          mv [NS];
  logic [W-1:0] md [NS];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NS*W-1:0] packModel();
    logic [NS*W-1:0] r;
    for (int i = 0; i < NS; i++) r[i*W +: W] = md[i];
    return r;
  endfunction

  function automatic logic [NS-1:0] validModel();
    logic [NS-1:0] r;
    for (int i = 0; i < NS; i++) r[i] = mv[i];
    return r;
  endfunction

  // Apply one cycle of inputs, check every output at the negedge against the
  // model, then advance the model to what the registers must hold after the edge.
  task automatic cycle(input bit iv, input logic [W-1:0] id,
                       input logic [NS-1:0] st, input logic [NS-1:0] fl, input bit rn);
    int hs, fk;
    bit          nv [NS];
    logic [W-1:0] nd [NS];
    bit          srcV;
    logic [W-1:0] srcD;
    logic [NS-1:0] expAdv;
    in_valid = iv; in_data = id; stall_req = st; flush = fl; resetn = rn;
    // Highest requesting stage: everything at or below it is covered.
    hs = -1; fk = -1;
    for (int j = 0; j < NS; j++) begin
      if (st[j]) hs = j;
      if (fl[j]) fk = j;
    end
    @(negedge clk);
    for (int i = 0; i < NS; i++) expAdv[i] = (fk >= i) || (hs < i);
    chk("in_ready", in_ready, rn && hs < 0 && fk < 0);
    chk("out_fire", out_fire, rn && mv[NS-1] && hs < NS-1 && fk < NS-1);
    chk("stage_adv", stage_adv, expAdv);
    chk("stage_valid", stage_valid, validModel());
    chk("stage_data", stage_data, packModel());
    chk("out_valid", out_valid, mv[NS-1]);
    chk("out_data", out_data, md[NS-1]);
    for (int i = 0; i < NS; i++) begin
      if (!rn) begin
        nv[i] = 0; nd[i] = '0;
      end else if (fk >= i) begin
        nv[i] = 0;
`ifdef PIPE_DATA_ZERO_EN
        nd[i] = '0;
`else
        nd[i] = md[i];
`endif
      end else if (hs >= i) begin
        nv[i] = mv[i]; nd[i] = md[i];
      end else begin
        // Predecessor only moves up if it is above both covered ranges.
        srcV = (i == 0) ? iv : (mv[i-1] && hs < i-1 && fk < i-1);
        srcD = (i == 0) ? id : md[i-1];
        nv[i] = srcV;
`ifdef PIPE_DATA_ZERO_EN
        nd[i] = srcV ? srcD : '0;
`else
        nd[i] = srcD;
`endif
      end
    end
    for (int i = 0; i < NS; i++) begin mv[i] = nv[i]; md[i] = nd[i]; end
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int t = 1; t <= 4; t++) cycle(1'b1, W'(t * 16), '0, '0, 1'b1);
  endtask

  logic [127:0] sdExp;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; stall_req = '0; flush = '0;
    for (int i = 0; i < NS; i++) begin mv[i] = 0; md[i] = '0; end
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_valid", stage_valid, 4'b0000);
    chk("rst_data", stage_data, 128'h0);
    chk("rst_out_fire", out_fire, 1'b0);

    // Streaming: beat 1 reaches the oldest stage after the 4th edge.
    for (int t = 1; t <= 4; t++) cycle(1'b1, W'(t), '0, '0, 1'b1);
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_out_data", out_data, 32'h1);
    for (int t = 5; t <= 8; t++) cycle(1'b1, W'(t), '0, '0, 1'b1);
    chk("stream_out_data", out_data, 32'h5);

    fill();
    chk("fill_data", stage_data, {32'h10, 32'h20, 32'h30, 32'h40});

    // Stall stages 0..1: stage 2 gets a bubble, stage 3 takes 0x20.
    cycle(1'b1, 32'h77, 4'b0010, '0, 1'b1);
    chk("stall_valid", stage_valid, 4'b1011);
`ifdef PIPE_DATA_ZERO_EN
    sdExp = {32'h20, 32'h00, 32'h30, 32'h40};
`else
    sdExp = {32'h20, 32'h30, 32'h30, 32'h40};
`endif
    chk("stall_data", stage_data, sdExp);

    // Flush stages 0..2: stage 3 receives a bubble, 0x99 is re-presented.
    fill();
    cycle(1'b1, 32'h99, '0, 4'b0100, 1'b1);
    chk("flush_valid", stage_valid, 4'b0000);
    cycle(1'b1, 32'h99, '0, '0, 1'b1);
    chk("flush_accept_valid", stage_valid, 4'b0001);
    chk("flush_accept_data", stage_data[31:0], 32'h99);

    // Stall everything while flushing 0..1: flush wins below, stall above.
    fill();
    cycle(1'b0, '0, 4'b1000, 4'b0010, 1'b1);
    chk("sf_valid", stage_valid, 4'b1100);
    chk("sf_data_hi", stage_data[127:64], {32'h10, 32'h20});

    // Mid-stream reset.
    fill();
    cycle(1'b1, 32'h5, '0, '0, 1'b0);
    chk("mid_rst_valid", stage_valid, 4'b0000);
    chk("mid_rst_data", stage_data, 128'h0);

    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom), $urandom,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
            ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000,
            $urandom_range(0, 60) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end
endmodule
